mealy_seq_detector_param: RTL and testbench

MEALY_SEQ_DETECTOR_PARAM -- requirements
Module: mealy_seq_detector_param

---
 rtl/mealy_seq_detector_param.sv | 86 ++++++++
 tb/tb_mealy_seq_detector_param.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mealy_seq_detector_param.sv
//------------------------------------------------------------------------------
// mealy_seq_detector_param : serial Mealy pattern detector with saturating match counter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mealy_seq_detector_param #(
   parameter int           N       = 5,
   parameter logic [N-1:0] PATTERN = 5'b11011,
   parameter int           OVERLAP = 0,
   parameter int           COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in,
   input  logic               en,
   input  logic               clear,
   output logic               out,
   output logic [COUNT_W-1:0] match_count
);

   localparam int             FILL_W    = (N > 2) ? $clog2(N) : 1;
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N - 1);

   generate
      if (N < 2 || N > 16) begin : g_bad_n
         $error("mealy_seq_detector_param: N must be in 2..16");
      end
   endgenerate

   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [N-2:0]       hist_q, hist_d;
   logic [N-2:0]       hist_shift;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               match;

   // A 2-bit pattern keeps a single history bit, so the shift collapses to a load.
   generate
      if (N == 2) begin : g_hist_n2
         assign hist_shift = in;
      end else begin : g_hist_wide
         assign hist_shift = {hist_q[N-3:0], in};
      end
   endgenerate

   assign match       = en && (fill_q == FILL_FULL) && ({hist_q, in} == PATTERN);
   assign out         = match;
   assign match_count = count_q;

   always_comb begin
      fill_d  = fill_q;
      hist_d  = hist_q;
      count_d = count_q;
      if (clear) begin
         fill_d  = '0;
         hist_d  = '0;
         count_d = '0;
      end else if (en) begin
         if (match && OVERLAP == 0) begin
            fill_d = '0;
            hist_d = '0;
         end else begin
            hist_d = hist_shift;
            fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
         end
         if (match && count_q != {COUNT_W{1'b1}}) begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fill_q  <= '0;
         hist_q  <= '0;
         count_q <= '0;
      end else begin
         fill_q  <= fill_d;
         hist_q  <= hist_d;
         count_q <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mealy_seq_detector_param.sv
// Directed bench for mealy_seq_detector_param: non-overlap, overlap and N=2 saturating variants.
`default_nettype none

module tb_mealy_seq_detector_param;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in = 1'b0, en = 1'b0, clear = 1'b0;
   logic       in2 = 1'b0, en2 = 1'b0, clear2 = 1'b0;
   logic       out0, out1, out2;
   logic [7:0] cnt0, cnt1;
   logic [1:0] cnt2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mealy_seq_detector_param #(.N(5), .PATTERN(5'b11011), .OVERLAP(0), .COUNT_W(8)) dut0 (
      .clk(clk), .rst(rst), .in(in), .en(en), .clear(clear), .out(out0), .match_count(cnt0));
   mealy_seq_detector_param #(.N(5), .PATTERN(5'b11011), .OVERLAP(1), .COUNT_W(8)) dut1 (
      .clk(clk), .rst(rst), .in(in), .en(en), .clear(clear), .out(out1), .match_count(cnt1));
   mealy_seq_detector_param #(.N(2), .PATTERN(2'b11), .OVERLAP(1), .COUNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in(in2), .en(en2), .clear(clear2), .out(out2), .match_count(cnt2));

   typedef struct packed {
      logic       rst_b4;
      logic       en;
      logic       in;
      logic       clear;
      logic       o0;
      logic       o1;
      logic [7:0] c0;
      logic [7:0] c1;
   } vec_t;

   vec_t tbl[17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; en = 1'b0; in = 1'b0; clear = 1'b0; en2 = 1'b0; in2 = 1'b0; clear2 = 1'b0;
      #1;
      chk("reset_out0", out0, 0);
      chk("reset_cnt1", cnt1, 0);
      #1;
      rst = 1'b1;
   endtask

   // Drive one bit at the falling edge, check the Mealy outputs, then let the rising edge take it.
   task automatic bit_chk(input logic e, input logic i, input logic c,
                          input logic x0, input logic x1, input string nm);
      @(negedge clk);
      en = e; in = i; clear = c;
      #1;
      chk({nm, "_out0"}, out0, x0);
      chk({nm, "_out1"}, out1, x1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Stream 1,1,0,1,1,0,1,1: non-overlap hits bit 5 only, overlap hits bits 5 and 8.
      tbl[0]  = '{1, 1, 1, 0, 0, 0, 8'd0, 8'd0};
      tbl[1]  = '{0, 1, 1, 0, 0, 0, 8'd0, 8'd0};
      tbl[2]  = '{0, 1, 0, 0, 0, 0, 8'd0, 8'd0};
      tbl[3]  = '{0, 1, 1, 0, 0, 0, 8'd0, 8'd0};
      tbl[4]  = '{0, 1, 1, 0, 1, 1, 8'd1, 8'd1};
      tbl[5]  = '{0, 1, 0, 0, 0, 0, 8'd1, 8'd1};
      tbl[6]  = '{0, 1, 1, 0, 0, 0, 8'd1, 8'd1};
      tbl[7]  = '{0, 1, 1, 0, 0, 1, 8'd1, 8'd2};
      // 1,1,0, three idle cycles with in toggling, 1, idle with in=1, 1.
      tbl[8]  = '{1, 1, 1, 0, 0, 0, 8'd0, 8'd0};
      tbl[9]  = '{0, 1, 1, 0, 0, 0, 8'd0, 8'd0};
      tbl[10] = '{0, 1, 0, 0, 0, 0, 8'd0, 8'd0};
      tbl[11] = '{0, 0, 1, 0, 0, 0, 8'd0, 8'd0};
      tbl[12] = '{0, 0, 0, 0, 0, 0, 8'd0, 8'd0};
      tbl[13] = '{0, 0, 1, 0, 0, 0, 8'd0, 8'd0};
      tbl[14] = '{0, 1, 1, 0, 0, 0, 8'd0, 8'd0};
      tbl[15] = '{0, 0, 1, 0, 0, 0, 8'd0, 8'd0};
      tbl[16] = '{0, 1, 1, 0, 1, 1, 8'd1, 8'd1};

      rst = 1'b0;
      #3;
      for (int i = 0; i < 17; i++) begin
         if (tbl[i].rst_b4) do_reset();
         @(negedge clk);
         en = tbl[i].en; in = tbl[i].in; clear = tbl[i].clear;
         #1;
         chk($sformatf("vec%0d_out0", i), out0, tbl[i].o0);
         chk($sformatf("vec%0d_out1", i), out1, tbl[i].o1);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_cnt0", i), cnt0, tbl[i].c0);
         chk($sformatf("vec%0d_cnt1", i), cnt1, tbl[i].c1);
      end

      // Reset pulsed mid-cycle discards 1101; five fresh bits are then needed.
      do_reset();
      bit_chk(1, 1, 0, 0, 0, "rs_b1");
      bit_chk(1, 1, 0, 0, 0, "rs_b2");
      bit_chk(1, 0, 0, 0, 0, "rs_b3");
      bit_chk(1, 1, 0, 0, 0, "rs_b4");
      @(negedge clk);
      en = 1'b1; in = 1'b1;
      #1;
      chk("rs_premat_out0", out0, 1);
      rst = 1'b0;
      #1;
      chk("rs_low_out0", out0, 0);
      chk("rs_low_cnt0", cnt0, 0);
      #1;
      rst = 1'b1;
      #1;
      chk("rs_first_out0", out0, 0);
      @(posedge clk);
      #1;
      bit_chk(1, 1, 0, 0, 0, "rs_p2");
      bit_chk(1, 0, 0, 0, 0, "rs_p3");
      bit_chk(1, 1, 0, 0, 0, "rs_p4");
      bit_chk(1, 1, 0, 1, 1, "rs_p5");
      chk("rs_cnt0", cnt0, 1);

      // clear on the completing bit wins: nothing counted, history emptied.
      do_reset();
      bit_chk(1, 1, 0, 0, 0, "cl_b1");
      bit_chk(1, 1, 0, 0, 0, "cl_b2");
      bit_chk(1, 0, 0, 0, 0, "cl_b3");
      bit_chk(1, 1, 0, 0, 0, "cl_b4");
      @(negedge clk);
      en = 1'b1; in = 1'b1; clear = 1'b1;
      @(posedge clk);
      #1;
      chk("cl_cnt0", cnt0, 0);
      chk("cl_cnt1", cnt1, 0);
      bit_chk(1, 1, 0, 0, 0, "cl_a1");
      bit_chk(1, 1, 0, 0, 0, "cl_a2");
      bit_chk(1, 0, 0, 0, 0, "cl_a3");
      bit_chk(1, 1, 0, 0, 0, "cl_a4");
      bit_chk(1, 1, 0, 1, 1, "cl_a5");
      chk("cl_after_cnt0", cnt0, 1);

      // N=2 overlapping 11 detector with a 2-bit counter: 7 matches, saturates at 3.
      do_reset();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         en2 = 1'b1; in2 = 1'b1;
         #1;
         chk($sformatf("sat%0d_out2", k), out2, (k > 0) ? 1 : 0);
         @(posedge clk);
         #1;
         chk($sformatf("sat%0d_cnt2", k), cnt2, (k > 3) ? 3 : k);
      end
      @(negedge clk);
      en2 = 1'b0;
      #1;
      chk("sat_idle_out2", out2, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
